// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic ADDR_MODE_WORD = 1'b0;
    localparam logic ADDR_MODE_BYTE = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable up-counter with a terminal flag at MAX; optionally saturating.
module mem_arb_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_term
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == WIDTH'(MAX));
    assign o_term = w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && !(SATURATE && w_term)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// load/store, with data-first priority, a fetch starvation guard and a timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_addr_mode,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_addr_mode,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall
);
    import mem_arb_pkg::*;

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    state_t r_state;
    owner_t w_owner;
    logic   w_idle, w_busy;
    logic   w_if_eff, w_d_eff;
    logic   w_grant_if, w_grant_d;
    logic   w_tmo_term, w_starve_term;
    logic   w_starve_inc, w_starve_clr;

    // A requester's own valid pulse masks the request it has not yet dropped.
    assign w_if_eff   = if_req & ~if_valid;
    assign w_d_eff    = d_req & ~d_valid;
    assign w_idle     = (r_state == IDLE);
    assign w_busy     = ~w_idle;
    assign w_grant_d  = w_idle & w_d_eff & ~(w_if_eff & w_starve_term);
    assign w_grant_if = w_idle & w_if_eff & ~w_grant_d;
    assign w_owner    = (r_state == BUSY_D) ? OWN_D : OWN_IF;

    assign w_starve_inc = w_grant_d & if_req;
    assign w_starve_clr = w_grant_if | (w_grant_d & ~if_req);

    assign stall = w_if_eff | w_d_eff;

    mem_arb_timer #(
        .WIDTH   (TMO_W),
        .MAX     (TIMEOUT - 1),
        .SATURATE(1'b0)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_grant_if | w_grant_d),
        .i_load_val('0),
        .i_inc     (w_busy),
        .o_term    (w_tmo_term)
    );

    mem_arb_timer #(
        .WIDTH   (STV_W),
        .MAX     (STARVE_MAX),
        .SATURATE(1'b1)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_starve_clr),
        .i_load_val('0),
        .i_inc     (w_starve_inc),
        .o_term    (w_starve_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_addr_mode <= ADDR_MODE_WORD;
            if_rdata      <= '0;
            d_rdata       <= '0;
            if_valid      <= 1'b0;
            d_valid       <= 1'b0;
            err           <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        mem_req       <= 1'b1;
                        mem_we        <= d_we;
                        mem_addr      <= d_addr;
                        mem_wdata     <= d_wdata;
                        mem_addr_mode <= d_addr_mode;
                        r_state       <= BUSY_D;
                    end else if (w_grant_if) begin
                        mem_req       <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= if_addr;
                        mem_wdata     <= '0;
                        mem_addr_mode <= ADDR_MODE_WORD;
                        r_state       <= BUSY_IF;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    // A ready in the terminal timeout cycle completes normally.
                    if (mem_ready || w_tmo_term) begin
                        mem_req <= 1'b0;
                        err     <= ~mem_ready;
                        r_state <= IDLE;
                        if (w_owner == OWN_D) begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and memory image.
module tb_mem_arbiter;

    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_addr_mode = 1'b0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_mode;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall;

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_MAX(SMAX),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_addr_mode  (d_addr_mode),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .err          (err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_mode(mem_addr_mode),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] gq [$];

    int   resp_age = 0;
    int   resp_lat = 0;
    bit   resp_never = 1'b0;
    bit   resp_rand = 1'b0;
    logic prev_mem_req = 1'b0;
    logic prev_if_valid = 1'b0;
    logic prev_d_valid = 1'b0;
    logic rise = 1'b0;

    bit   if_busy, d_busy, pif_eff, pd_eff, pif_req, pidle, is_d, exp_d;
    int   s_cnt, ncomp, n;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: memory responder acts at the falling edge, then global invariants.
    task automatic step();
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            resp_age++;
            if (!resp_never && resp_age == resp_lat + 1) begin
                mem_ready = 1'b1;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = rd_mem(mem_addr);
                resp_age = 0;
                if (resp_rand) resp_lat = int'($urandom_range(0, 4));
            end
        end else begin
            resp_age = 0;
        end
        rise = mem_req & ~prev_mem_req;
        if (rise) gq.push_back(mem_addr);
        prev_mem_req = mem_req;
        chk("valid_overlap", 32'(if_valid & d_valid), 32'd0);
        chk("if_pulse_len", 32'(if_valid & prev_if_valid), 32'd0);
        chk("d_pulse_len", 32'(d_valid & prev_d_valid), 32'd0);
        prev_if_valid = if_valid;
        prev_d_valid  = d_valid;
    endtask

    task automatic reset_dut();
        rst_n  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step();

        // IF only, memory answers one cycle after mem_req
        mem_model[32'h10] = 32'hDEADBEEF;
        resp_lat = 1;
        if_addr = 32'h10;
        if_req = 1'b1;
        #1 chk("t1_stall_c0", 32'(stall), 32'd1);
        step();
        chk("t1_mem_req_c1", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_stall_c1", 32'(stall), 32'd1);
        step();
        chk("t1_valid_c2", 32'(if_valid), 32'd0);
        chk("t1_stall_c2", 32'(stall), 32'd1);
        step();
        chk("t1_valid_c3", 32'(if_valid), 32'd1);
        chk("t1_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_stall_c3", 32'(stall), 32'd0);
        if_req = 1'b0;
        step();
        chk("t1_no_regrant", 32'(mem_req), 32'd0);

        // Simultaneous requests: D store wins, then IF
        resp_lat = 0;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55; d_addr_mode = 1'b1;
        if_addr = 32'h20;
        d_req = 1'b1; if_req = 1'b1;
        step();
        chk("t2_mem_we", 32'(mem_we), 32'd1);
        chk("t2_mem_mode", 32'(mem_addr_mode), 32'd1);
        chk("t2_mem_wdata", mem_wdata, 32'h55);
        chk("t2_mem_addr", mem_addr, 32'h100);
        step();
        chk("t2_d_valid", 32'(d_valid), 32'd1);
        chk("t2_if_not_yet", 32'(if_valid), 32'd0);
        d_req = 1'b0;
        step();
        chk("t2_if_granted", 32'(mem_req), 32'd1);
        chk("t2_if_addr", mem_addr, 32'h20);
        chk("t2_if_we", 32'(mem_we), 32'd0);
        chk("t2_if_mode", 32'(mem_addr_mode), 32'd0);
        step();
        chk("t2_if_valid", 32'(if_valid), 32'd1);
        chk("t2_if_rdata", if_rdata, dflt(32'h20));
        chk("t2_store_landed", rd_mem(32'h100), 32'h55);
        if_req = 1'b0;
        step();

        // Starvation guard: IF drops only during D's valid cycle
        gq.delete();
        if_addr = 32'h30;
        d_we = 1'b0; d_addr = 32'h200; d_addr_mode = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 200 && gq.size() < 10; k++) begin
            step();
            if_req = ~d_valid;
        end
        d_req = 1'b0;
        if_req = 1'b1;
        for (int k = 0; k < 20 && !if_valid; k++) step();
        if_req = 1'b0;
        step();
        chk("t3_grant_count", 32'(gq.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_order%0d", k), (k < gq.size()) ? gq[k] : 32'hFFFF_FFFF,
                ((k % 5) == 4) ? 32'h30 : 32'h200);
        end

        // Timeout with no mem_ready
        resp_never = 1'b1;
        d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
        step();
        n = 0;
        for (int k = 0; k < 200 && mem_req; k++) begin n++; step(); end
        chk("t4_busy_cycles", 32'(n), 32'(TMO));
        chk("t4_d_valid", 32'(d_valid), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        resp_never = 1'b0;
        resp_lat = 1;
        step();
        chk("t4_err_pulse", 32'(err), 32'd0);
        d_addr = 32'h304; d_req = 1'b1;
        step();
        chk("t4_regrant", 32'(mem_req), 32'd1);
        chk("t4_regrant_addr", mem_addr, 32'h304);
        step();
        step();
        chk("t4_next_valid", 32'(d_valid), 32'd1);
        chk("t4_next_err", 32'(err), 32'd0);
        chk("t4_next_rdata", d_rdata, dflt(32'h304));
        d_req = 1'b0;
        step();

        // Ready in the terminal timeout cycle wins
        resp_lat = TMO - 1;
        d_addr = 32'h308; d_req = 1'b1;
        step();
        n = 0;
        for (int k = 0; k < 200 && mem_req; k++) begin n++; step(); end
        chk("t4b_busy_cycles", 32'(n), 32'(TMO));
        chk("t4b_d_valid", 32'(d_valid), 32'd1);
        chk("t4b_err", 32'(err), 32'd0);
        chk("t4b_rdata", d_rdata, dflt(32'h308));
        d_req = 1'b0;
        step();

        // Reset asserted in the third BUSY_D cycle
        resp_never = 1'b1;
        d_addr = 32'h400; d_req = 1'b1;
        repeat (3) step();
        chk("t5_busy", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1 chk("t5_async_drop", 32'(mem_req), 32'd0);
        step();
        chk("t5_no_valid_a", 32'(d_valid), 32'd0);
        step();
        chk("t5_no_valid_b", 32'(d_valid), 32'd0);
        resp_never = 1'b0;
        resp_lat = 0;
        rst_n = 1'b1;
        step();
        chk("t5_no_valid_c", 32'(d_valid), 32'd0);
        chk("t5_regrant", 32'(mem_req), 32'd1);
        chk("t5_regrant_addr", mem_addr, 32'h400);
        step();
        chk("t5_valid", 32'(d_valid), 32'd1);
        chk("t5_rdata", d_rdata, dflt(32'h400));
        d_req = 1'b0;
        step();

        // First-cycle ready, IF holds req through its valid cycle
        if_addr = 32'h50; if_req = 1'b1;
        step();
        chk("t6_granted", 32'(mem_req), 32'd1);
        step();
        chk("t6_valid", 32'(if_valid), 32'd1);
        chk("t6_rdata", if_rdata, dflt(32'h50));
        step();
        chk("t6_valid_once", 32'(if_valid), 32'd0);
        chk("t6_no_regrant", 32'(mem_req), 32'd0);
        if_req = 1'b0;
        step();
        chk("t6_still_idle", 32'(mem_req), 32'd0);

        // Stray mem_ready in IDLE
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("t7_no_if_valid", 32'(if_valid), 32'd0);
        chk("t7_no_d_valid", 32'(d_valid), 32'd0);
        chk("t7_if_rdata_kept", if_rdata, dflt(32'h50));
        chk("t7_no_req", 32'(mem_req), 32'd0);

        // Randomized traffic against the reference model
        reset_dut();
        s_cnt = 0; ncomp = 0;
        if_busy = 1'b0; d_busy = 1'b0;
        pif_eff = 1'b0; pd_eff = 1'b0; pif_req = 1'b0; pidle = 1'b1;
        resp_rand = 1'b1;
        resp_lat = int'($urandom_range(0, 4));
        for (int c = 0; c < 3000; c++) begin
            step();
            if (pidle && (pif_eff || pd_eff)) chk("rnd_grant_taken", 32'(rise), 32'd1);
            if (rise) begin
                chk("rnd_grant_from_idle", 32'(pidle), 32'd1);
                is_d  = mem_addr[28];
                exp_d = (pif_eff && pd_eff) ? (s_cnt != int'(SMAX)) : pd_eff;
                chk("rnd_grant_owner", 32'(is_d), 32'(exp_d));
                if (is_d) begin
                    chk("rnd_d_addr", mem_addr, d_addr);
                    chk("rnd_d_we", 32'(mem_we), 32'(d_we));
                    chk("rnd_d_mode", 32'(mem_addr_mode), 32'(d_addr_mode));
                    if (d_we) chk("rnd_d_wdata", mem_wdata, d_wdata);
                    d_busy = 1'b1;
                    s_cnt = pif_req ? ((s_cnt < int'(SMAX)) ? s_cnt + 1 : int'(SMAX)) : 0;
                end else begin
                    chk("rnd_if_addr", mem_addr, if_addr);
                    chk("rnd_if_we", 32'(mem_we), 32'd0);
                    chk("rnd_if_mode", 32'(mem_addr_mode), 32'd0);
                    if_busy = 1'b1;
                    s_cnt = 0;
                end
            end
            if (if_valid) begin
                chk("rnd_if_expected", 32'(if_busy), 32'd1);
                chk("rnd_if_rdata", if_rdata, ref_rd(if_addr));
                chk("rnd_if_err", 32'(err), 32'd0);
                if_busy = 1'b0;
                ncomp++;
            end
            if (d_valid) begin
                chk("rnd_d_expected", 32'(d_busy), 32'd1);
                if (d_we) ref_mem[d_addr] = d_wdata;
                else      chk("rnd_d_rdata", d_rdata, ref_rd(d_addr));
                chk("rnd_d_err", 32'(err), 32'd0);
                d_busy = 1'b0;
                ncomp++;
            end
            if (!if_valid && !d_valid) chk("rnd_stall", 32'(stall), 32'(if_req | d_req));

            if (if_valid) if_req = 1'b0;
            if (!if_req && c < 2800 && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h40 | (32'($urandom_range(0, 7)) << 2);
            end
            if (d_valid) d_req = 1'b0;
            if (!d_req && c < 2800 && $urandom_range(0, 2) == 0) begin
                d_req       = 1'b1;
                d_we        = 1'($urandom_range(0, 1));
                d_addr_mode = 1'($urandom_range(0, 1));
                d_wdata     = $urandom;
                d_addr      = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
            end
            pif_eff = if_req & ~if_valid;
            pd_eff  = d_req & ~d_valid;
            pif_req = if_req;
            pidle   = ~if_busy & ~d_busy;
        end
        chk("rnd_drained", 32'(if_busy | d_busy | if_req | d_req), 32'd0);
        chk("rnd_traffic_seen", 32'(ncomp > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
